// File: rtl/turn_light_seq_pkg.sv
// -----------------------------------------------------------------------------
// turn_pkg
// Shared constants for the turn-light sequencer: mode encodings, per-mode
// pattern tables, step counts and a small helper giving the final step index
// of each mode.
// -----------------------------------------------------------------------------
package turn_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [2:0] step_t;

  // Mode encodings; the numeric values are visible on the mode output.
  localparam mode_t MODE_IDLE   = 2'd0;
  localparam mode_t MODE_LEFT   = 2'd1;
  localparam mode_t MODE_RIGHT  = 2'd2;
  localparam mode_t MODE_HAZARD = 2'd3;

  // Number of pattern steps in each active mode.
  localparam int LEFT_STEPS   = 5;
  localparam int RIGHT_STEPS  = 5;
  localparam int HAZARD_STEPS = 2;

  // Left bank (led[7:4]) sweeps outward, then a dark step.
  localparam logic [3:0] LEFT_PAT [0:4] = '{
    4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000
  };

  // Right bank (led[3:0]) sweeps outward from the other end, then dark.
  localparam logic [3:0] RIGHT_PAT [0:4] = '{
    4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000
  };

  // Hazard flashes every lamp together.
  localparam logic [7:0] HAZARD_PAT [0:1] = '{
    8'hFF, 8'h00
  };

  // Index of the last step before wrapping back to step 0.
  function automatic step_t last_step(input mode_t m);
    step_t s;
    case (m)
      MODE_LEFT:   s = step_t'(LEFT_STEPS - 1);
      MODE_RIGHT:  s = step_t'(RIGHT_STEPS - 1);
      MODE_HAZARD: s = step_t'(HAZARD_STEPS - 1);
      default:     s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/turn_light_seq_if.sv
// -----------------------------------------------------------------------------
// turn_light_seq_if
// Request/strobe inputs and lamp/status outputs of the turn-light sequencer.
//   clk_bps    : one-cycle timebase strobe
//   left_req   : left turn request (level)
//   right_req  : right turn request (level)
//   hazard_req : hazard request (level)
//   led        : lamp drive, [7:4] left bank, [3:0] right bank
//   mode       : current mode (0 idle, 1 left, 2 right, 3 hazard)
//   busy       : high whenever mode is not idle
// master = request side, slave = sequencer.
// -----------------------------------------------------------------------------
interface turn_light_seq_if;

  logic       clk_bps;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic [7:0] led;
  logic [1:0] mode;
  logic       busy;

  modport master (
    output clk_bps,
    output left_req,
    output right_req,
    output hazard_req,
    input  led,
    input  mode,
    input  busy
  );

  modport slave (
    input  clk_bps,
    input  left_req,
    input  right_req,
    input  hazard_req,
    output led,
    output mode,
    output busy
  );

endinterface

// File: rtl/turn_light_seq_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Counts clk_bps strobes and emits step_en on the strobe that completes a
// group of STEP_TICKS strobes. A level-high strobe counts once per cycle.
//   clk        : system clock
//   rst_n      : asynchronous reset, active HIGH
//   clr_i      : synchronous clear, overrides counting
//   en_i       : counting enable
//   clk_bps_i  : timebase strobe
//   step_en_o  : one-cycle pulse, advance the pattern at this edge
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int STEP_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic clk_bps_i,
  output logic step_en_o
);

  localparam logic [3:0] LAST_CNT = 4'(STEP_TICKS - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    step_en_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && clk_bps_i) begin
      // ">=" keeps the counter inside 0..LAST_CNT even if it were disturbed.
      if (cnt_q >= LAST_CNT) begin
        cnt_d     = '0;
        step_en_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_light_seq.sv
// -----------------------------------------------------------------------------
// turn_light_seq
// Turn-signal lamp sequencer. Decodes the requested mode every cycle, restarts
// the pattern whenever the mode changes and advances the pattern once every
// STEP_TICKS clk_bps strobes. All outputs decode registered state only.
//   clk    : system clock
//   rst_n  : asynchronous reset, active HIGH (name kept for compatibility)
//   bus    : request/strobe inputs, lamp/mode/busy outputs (slave side)
//
//   state       | meaning
//   ------------+----------------------------------------------
//   MODE_IDLE   | all lamps off, strobes ignored
//   MODE_LEFT   | left bank sweep, 5 steps
//   MODE_RIGHT  | right bank sweep, 5 steps
//   MODE_HAZARD | all lamps flash, 2 steps
// -----------------------------------------------------------------------------
module turn_light_seq
  import turn_pkg::*;
#(
  parameter int STEP_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  turn_light_seq_if.slave  bus
);

  mode_t mode_q;
  mode_t mode_d;
  step_t step_q;
  step_t step_d;
  mode_t target_mode;
  logic  mode_change;
  logic  step_en;
  logic  presc_clr;
  logic  presc_en;
  logic [7:0] led;

  // Hazard wins, and both turn requests together also mean hazard.
  always_comb begin
    if (bus.hazard_req || (bus.left_req && bus.right_req)) begin
      target_mode = MODE_HAZARD;
    end else if (bus.left_req) begin
      target_mode = MODE_LEFT;
    end else if (bus.right_req) begin
      target_mode = MODE_RIGHT;
    end else begin
      target_mode = MODE_IDLE;
    end
  end

  assign mode_change = (target_mode != mode_q);

  // The prescaler is held clear in idle so a later mode starts from a fresh
  // count, and cleared on a mode change even if a strobe is present.
  assign presc_clr = mode_change || (mode_q == MODE_IDLE);
  assign presc_en  = !presc_clr;

  tick_prescaler #(
    .STEP_TICKS (STEP_TICKS)
  ) u_tick_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (presc_clr),
    .en_i      (presc_en),
    .clk_bps_i (bus.clk_bps),
    .step_en_o (step_en)
  );

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (mode_change) begin
      mode_d = target_mode;
      step_d = '0;
    end else if (mode_q == MODE_IDLE) begin
      step_d = '0;
    end else if (step_en) begin
      if (step_q >= last_step(mode_q)) begin
        step_d = '0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mode_q <= MODE_IDLE;
      step_q <= '0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  // Lamp decode from registered mode/step only.
  always_comb begin
    led = 8'h00;
    case (mode_q)
      MODE_LEFT: begin
        if (step_q <= last_step(MODE_LEFT)) begin
          led = {LEFT_PAT[step_q], 4'b0000};
        end
      end
      MODE_RIGHT: begin
        if (step_q <= last_step(MODE_RIGHT)) begin
          led = {4'b0000, RIGHT_PAT[step_q]};
        end
      end
      MODE_HAZARD: begin
        led = HAZARD_PAT[step_q[0]];
      end
      default: begin
        led = 8'h00;
      end
    endcase
  end

  assign bus.led  = led;
  assign bus.mode = mode_q;
  assign bus.busy = (mode_q != MODE_IDLE);

endmodule

// File: tb/tb_turn_light_seq.sv
module tb_turn_light_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic bps, lreq, rreq, hreq;

  always #5 clk = ~clk;

  turn_light_seq_if bus2 ();
  turn_light_seq_if bus1 ();

  assign bus2.clk_bps    = bps;
  assign bus2.left_req   = lreq;
  assign bus2.right_req  = rreq;
  assign bus2.hazard_req = hreq;
  assign bus1.clk_bps    = bps;
  assign bus1.left_req   = lreq;
  assign bus1.right_req  = rreq;
  assign bus1.hazard_req = hreq;

  turn_light_seq #(.STEP_TICKS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  turn_light_seq #(.STEP_TICKS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 models STEP_TICKS=2, index 1 models STEP_TICKS=1.
  int ticks [2] = '{2, 1};
  int m_mode [2];
  int m_step [2];
  int m_cnt  [2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int target(input logic l, input logic r, input logic h);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  function automatic int seq_len(input int m);
    if (m == 3) return 2;
    if (m == 0) return 1;
    return 5;
  endfunction

  // Lamp pattern from the written rules: left fills from led[4] upward,
  // right fills from led[3] downward, step 4 dark; hazard on/off.
  function automatic logic [7:0] exp_led(input int m, input int s);
    int b;
    b = 0;
    case (m)
      1: b = (s < 4) ? (((1 << (s + 1)) - 1) << 4) : 0;
      2: b = (s < 4) ? ((15 << (3 - s)) & 15) : 0;
      3: b = (s == 0) ? 255 : 0;
      default: b = 0;
    endcase
    return b[7:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_step[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    int t;
    if (rst_n) begin
      model_reset();
      return;
    end
    t = target(lreq, rreq, hreq);
    for (int k = 0; k < 2; k++) begin
      if (t != m_mode[k]) begin
        m_mode[k] = t; m_step[k] = 0; m_cnt[k] = 0;
      end else if (m_mode[k] != 0 && bps) begin
        m_cnt[k]++;
        if (m_cnt[k] == ticks[k]) begin
          m_cnt[k] = 0;
          m_step[k] = (m_step[k] + 1) % seq_len(m_mode[k]);
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [7:0] el;
    el = exp_led(m_mode[0], m_step[0]);
    chk({ph, "/T2 led"},  bus2.led, el);
    chk({ph, "/T2 mode"}, {6'b0, bus2.mode}, 8'(m_mode[0]));
    chk({ph, "/T2 busy"}, {7'b0, bus2.busy}, {7'b0, m_mode[0] != 0});
    el = exp_led(m_mode[1], m_step[1]);
    chk({ph, "/T1 led"},  bus1.led, el);
    chk({ph, "/T1 mode"}, {6'b0, bus1.mode}, 8'(m_mode[1]));
    chk({ph, "/T1 busy"}, {7'b0, bus1.busy}, {7'b0, m_mode[1] != 0});
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, check.
  task automatic cycle(input string ph, input logic b, input logic l, input logic r, input logic h);
    bps = b; lreq = l; rreq = r; hreq = h;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  logic [7:0] right_seq [4] = '{8'h08, 8'h0C, 8'h0E, 8'h0F};
  int guard;
  logic cl, cr, ch;

  initial begin
    rst_n = 1'b1;
    bps = 0; lreq = 0; rreq = 0; hreq = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    check_all("reset_hold");
    rst_n = 1'b0;

    // Idle with the strobe toggling, then a right request.
    for (int i = 0; i < 100; i++) cycle("idle_bps", 1'(i % 2), 0, 0, 0);
    cycle("idle_to_right", 0, 0, 1, 0);
    chk("idle_to_right/T2 led08", bus2.led, 8'h08);
    cycle("to_idle", 0, 0, 0, 0);

    // Left with a strobe every 10 cycles.
    for (int i = 0; i < 130; i++) cycle("left_slow", 1'(i % 10 == 0), 1, 0, 0);

    // Both turn requests -> hazard, then drop right.
    for (int i = 0; i < 20; i++) cycle("both", 1'(i % 3 == 0), 1, 1, 0);
    chk("both/T2 mode3", {6'b0, bus2.mode}, 8'd3);
    cycle("drop_right", 0, 1, 0, 0);
    chk("drop_right/T2 led10", bus2.led, 8'h10);
    chk("drop_right/T1 led10", bus1.led, 8'h10);

    // Request change on the strobe that would complete a prescaler group.
    cycle("pre_change", 1, 1, 0, 0);
    cycle("change_on_bps", 1, 0, 1, 0);
    chk("change_on_bps/T2 led08", bus2.led, 8'h08);
    cycle("after_change", 1, 0, 1, 0);
    chk("after_change/T2 led08", bus2.led, 8'h08);

    // STEP_TICKS=1 with the strobe held high in right mode.
    cycle("to_idle2", 0, 0, 0, 0);
    cycle("right_enter", 0, 0, 1, 0);
    chk("held_bps/T1 step0", bus1.led, right_seq[0]);
    for (int i = 1; i < 4; i++) begin
      cycle("held_bps", 1, 0, 1, 0);
      chk($sformatf("held_bps/T1 step%0d", i), bus1.led, right_seq[i]);
    end

    // Asynchronous reset in the middle of left step 2.
    cycle("to_idle3", 0, 0, 0, 0);
    cycle("left_enter", 0, 1, 0, 0);
    guard = 0;
    while (m_step[0] != 2 && guard < 50) begin
      cycle("left_run", 1, 1, 0, 0);
      guard++;
    end
    chk("reach_step2/T2 led", bus2.led, 8'h70);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst/T2 led",  bus2.led, 8'h00);
    chk("async_rst/T2 mode", {6'b0, bus2.mode}, 8'd0);
    chk("async_rst/T2 busy", {7'b0, bus2.busy}, 8'd0);
    chk("async_rst/T1 led",  bus1.led, 8'h00);
    model_reset();
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b0;
    cycle("reenter_left", 0, 1, 0, 0);
    chk("reenter_left/T2 led10", bus2.led, 8'h10);

    // Randomized requests and strobes.
    cl = 0; cr = 0; ch = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cl = 1'($urandom_range(0, 1));
        cr = 1'($urandom_range(0, 1));
        ch = ($urandom_range(0, 5) == 0);
      end
      cycle("random", ($urandom_range(0, 2) == 0), cl, cr, ch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
